// File: rtl/mul_unit_pipelined_tagged.sv
// Pipelined, tagged RV32M/RV64M multiply unit (MUL, MULH, MULHSU, MULHU).
// An operation accepted in cycle N lands in an in-order first-word-fall-through
// FIFO at the edge ending cycle N+MUL_CYCLES-1. Issue credits count both pipeline
// and FIFO occupancy, so the FIFO never overflows and the pipeline never stalls.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   issue_valid/ready, issue_op, issue_rs1, issue_rs2, issue_id   issue side
//   flush           synchronous discard of everything in flight or buffered
//   wb_valid, wb_data, wb_id, wb_accepted                         writeback side
//   inflight        pipeline + FIFO occupancy
module mul_unit_pipelined_tagged #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_WIDTH   = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue_valid,
    output logic                              issue_ready,
    input  logic [1:0]                        issue_op,
    input  logic [XLEN-1:0]                   issue_rs1,
    input  logic [XLEN-1:0]                   issue_rs2,
    input  logic [ID_WIDTH-1:0]               issue_id,
    input  logic                              flush,
    output logic                              wb_valid,
    output logic [XLEN-1:0]                   wb_data,
    output logic [ID_WIDTH-1:0]               wb_id,
    input  logic                              wb_accepted,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   inflight
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic             accept;
    logic             pop;
    logic             push;
    logic             a_signed;
    logic             b_signed;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod0;

    logic                last_valid;
    logic [1:0]          last_op;
    logic [ID_WIDTH-1:0] last_id;
    logic [2*XLEN-1:0]   last_prod;
    logic [XLEN-1:0]     push_data;

    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

    logic [XLEN-1:0]     data_mem [FIFO_DEPTH];
    logic [ID_WIDTH-1:0] id_mem   [FIFO_DEPTH];

    assign issue_ready = (inflight_q < CNT_W'(FIFO_DEPTH));
    assign wb_valid    = (count_q != '0);
    assign accept      = issue_valid & issue_ready & ~flush;
    assign pop         = wb_accepted & wb_valid & ~flush;

    // Operand extension: A signed for MULH/MULHSU, B signed only for MULH.
    // The full 2*XLEN product of the extended operands is exact modulo 2^(2*XLEN).
    always_comb begin
        a_signed = (issue_op == 2'b01) || (issue_op == 2'b10);
        b_signed = (issue_op == 2'b01);
        a_ext    = {{XLEN{a_signed & issue_rs1[XLEN-1]}}, issue_rs1};
        b_ext    = {{XLEN{b_signed & issue_rs2[XLEN-1]}}, issue_rs2};
        prod0    = a_ext * b_ext;
    end

    // MUL_CYCLES-1 register stages follow the combinational first stage; the FIFO
    // write is the final edge. Retiming is expected to spread the multiplier across them.
    if (MUL_CYCLES == 1) begin : g_direct
        assign last_valid = accept;
        assign last_op    = issue_op;
        assign last_id    = issue_id;
        assign last_prod  = prod0;
    end else begin : g_pipe
        localparam int NS = int'(MUL_CYCLES) - 1;
        logic                vld  [NS];
        logic [1:0]          op   [NS];
        logic [ID_WIDTH-1:0] tag  [NS];
        logic [2*XLEN-1:0]   prod [NS];

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                for (int i = 0; i < NS; i++) vld[i] <= 1'b0;
            end else begin
                vld[0] <= accept;
                for (int i = 1; i < NS; i++) vld[i] <= vld[i-1];
            end
        end

        always_ff @(posedge clk) begin
            op[0]   <= issue_op;
            tag[0]  <= issue_id;
            prod[0] <= prod0;
            for (int i = 1; i < NS; i++) begin
                op[i]   <= op[i-1];
                tag[i]  <= tag[i-1];
                prod[i] <= prod[i-1];
            end
        end

        assign last_valid = vld[NS-1];
        assign last_op    = op[NS-1];
        assign last_id    = tag[NS-1];
        assign last_prod  = prod[NS-1];
    end

    assign push      = last_valid & ~flush;
    assign push_data = (last_op == 2'b00) ? last_prod[XLEN-1:0] : last_prod[2*XLEN-1:XLEN];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        unique case ({accept, pop})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= push_data;
            id_mem[wr_ptr_q]   <= last_id;
        end
    end

    assign wb_data  = data_mem[rd_ptr_q];
    assign wb_id    = id_mem[rd_ptr_q];
    assign inflight = inflight_q;

endmodule
